// File: rtl/arm_pipe_pkg.sv
// Shared types and sizing for the ARM pipeline sequencer.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 16;

  // The wait timer must hold values up to MEM_TIMEOUT - 1, with one bit of headroom.
  function automatic int timer_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

  localparam int TIMER_W_DEF = timer_w(MEM_TIMEOUT_DEF);

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns hazard, branch and data-memory
// handshake events into per-register freeze/flush/bubble controls.
module pipe_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_freeze,
  output logic             idex_flush,
  output logic             exmem_freeze,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                 TIMER_W    = timer_w(MEM_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               hold;
  logic               decode_ok;
  logic               branch_act;

  // Memory stall outranks branch, branch outranks hazard; nothing drives while in reset.
  always_comb begin
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_freeze  = 1'b0;
    idex_flush   = 1'b0;
    exmem_freeze = 1'b0;
    memwb_bubble = 1'b0;
    hold         = 1'b0;
    decode_ok    = 1'b0;
    branch_act   = 1'b0;
    if (rst) begin
      case (state)
        RUN:      begin
          hold      = mem_req && !mem_ready;
          decode_ok = !hold;
        end
        MEM_WAIT: begin
          hold      = !mem_ready;
          decode_ok = mem_ready;
        end
        ERR:      hold = 1'b1;
        default:  hold = 1'b0;
      endcase
      if (hold) begin
        pc_freeze    = 1'b1;
        ifid_freeze  = 1'b1;
        idex_freeze  = 1'b1;
        exmem_freeze = 1'b1;
        memwb_bubble = 1'b1;
      end
      if (decode_ok) begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          branch_act = 1'b1;
        end else if (hazard) begin
          pc_freeze   = 1'b1;
          ifid_freeze = 1'b1;
          idex_flush  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      timer   <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state <= MEM_WAIT;
            timer <= TIMER_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_freeze),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch_act),
    .q   (flush_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage ARM core (IF, ID, EX, MEM, WB).
- Drives the freeze/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, and the bubble control of MEM/WB.
- Decisions come from three sources: hazard detection, EX-stage branch resolution and the multi-cycle data-memory handshake.
- Adds a memory-timeout watchdog and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: cycles allowed in MEM_WAIT before entering ERR; legal range 2..65535.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- hazard  in  1  RAW hazard flagged by the hazard unit for the instruction in ID.
- branch_taken  in  1  B instruction in EX is taken this cycle.
- mem_req  in  1  EX/MEM holds a load or store (mem_read_out | mem_write_out).
- mem_ready  in  1  data memory completes the current access this cycle.
- pc_freeze  out  1  hold the PC.
- ifid_freeze  out  1  hold IF/ID.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_freeze  out  1  hold ID/EX.
- idex_flush  out  1  load a bubble into ID/EX: all control bits 0.
- exmem_freeze  out  1  hold EX/MEM.
- memwb_bubble  out  1  write a bubble into MEM/WB: wb_en 0.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles in which pc_freeze = 1.
- flush_cnt  out  CNT_W  taken branches that were acted on.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Next state is registered; control outputs are Mealy, combinational from state and inputs.
- Reset (rst = 0, asynchronous): state = RUN, timer = 0, mem_err = 0, both counters = 0. All control outputs are forced to 0 while rst = 0.
- Priority within a cycle: memory stall > branch > hazard.
- RUN with mem_req = 1 and mem_ready = 0:
  - assert pc_freeze, ifid_freeze, idex_freeze, exmem_freeze and memwb_bubble;
  - next state MEM_WAIT, timer <= 1;
  - branch and hazard inputs are ignored that cycle.
- RUN with mem_req = 1 and mem_ready = 1: single-cycle access, no stall; branch and hazard are then evaluated as below.
- RUN with branch_taken = 1: assert ifid_flush and idex_flush (two wrong-path instructions); flush_cnt increments. Hazard is ignored, because the instruction in ID is discarded.
- RUN with hazard = 1 and no branch: assert pc_freeze, ifid_freeze and idex_flush, giving a one-cycle bubble per asserted cycle.
- MEM_WAIT with mem_ready = 0:
  - all four freezes and memwb_bubble stay asserted;
  - timer increments;
  - when timer = MEM_TIMEOUT - 1 and mem_ready = 0, next state is ERR.
- MEM_WAIT with mem_ready = 1:
  - freezes drop in the same cycle and next state is RUN;
  - a branch_taken or hazard present that cycle is acted on exactly as in RUN;
  - a branch held frozen in EX during the wait is therefore counted once, on release.
- ERR:
  - all four freezes asserted;
  - memwb_bubble = 1, idex_flush = 0, ifid_flush = 0;
  - mem_err = 1;
  - the only exit is reset.
- Counters:
  - each saturates at 2^CNT_W - 1 and never wraps;
  - the increment is registered, so the counter updates on the clock edge that ends the qualifying cycle;
  - stall_cnt counts every cycle with pc_freeze = 1, including ERR cycles.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with outputs 0; the pending access is abandoned, and the memory controller is reset by the same rst.
- mem_ready with mem_req = 0 has no effect.

Decomposition:
- Package arm_pipe_pkg holds:
  - the state enum (RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2);
  - the default MEM_TIMEOUT and CNT_W values;
  - the timer width, $clog2(MEM_TIMEOUT) + 1.
- One sub-module, sat_counter (parameter W, inputs clk, rst, inc; output q), instantiated for stall_cnt and flush_cnt.
- FSM and output decode stay in pipe_ctrl.

Test Plan:
- Reset: rst low for 3 cycles with hazard = 1 and branch_taken = 1 -> all outputs 0, counters 0; after release, hazard = 1 -> pc_freeze = ifid_freeze = idex_flush = 1 in the same cycle.
- Load-use: hazard high for 2 cycles -> 2 bubble cycles, stall_cnt = 2, flush_cnt = 0, no freeze on idex or exmem.
- Branch plus hazard in the same cycle -> ifid_flush = idex_flush = 1, pc_freeze = 0, flush_cnt = 1, stall_cnt unchanged.
- Memory wait: mem_req = 1 with mem_ready low for 5 cycles, then high -> freezes high for 5 cycles and low on the ready cycle; stall_cnt = 5; state back to RUN.
- Timeout: MEM_TIMEOUT = 4, mem_req = 1, mem_ready held 0 -> ERR entered after 4 stalled cycles, mem_err = 1 and sticky; mem_ready = 1 later has no effect; rst clears it.
- Saturation: CNT_W = 3, hazard held for 10 cycles -> stall_cnt reaches 7 and stays at 7.
